mem_arbiter: RTL and testbench

Shares a single unified memory bus port between the instruction-fetch stage and the memory-access stage of the 5-stage RV32I pipeline. It serialises the two request streams, runs one bus transaction at a time, and returns read data and completion to the owning requester. It also raises per-stage stall requests toward the pipeline stall controller while a requester is waiting.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 54 +++++
 rtl/mem_arbiter_pick2.sv | 33 +++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM unified-bus arbiter.
// Optional round-robin tie-break: define MEM_ARB_RR_EN.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, bus and stall-request bundle of the memory arbiter.
// master = arbiter view, slave = pipeline/memory view.
interface mem_arbiter_if #(
  parameter int ADDR_W = mem_arb_pkg::ADDR_W_DEF,
  parameter int DATA_W = mem_arb_pkg::DATA_W_DEF
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic                dm_req;
  logic                dm_we;
  logic [DATA_W/8-1:0] dm_be;
  logic [ADDR_W-1:0]   dm_addr;
  logic [DATA_W-1:0]   dm_wdata;
  logic                dm_gnt;
  logic                dm_rvalid;
  logic [DATA_W-1:0]   dm_rdata;

  logic                bus_req;
  logic                bus_we;
  logic [DATA_W/8-1:0] bus_be;
  logic [ADDR_W-1:0]   bus_addr;
  logic [DATA_W-1:0]   bus_wdata;
  logic                bus_ready;
  logic [DATA_W-1:0]   bus_rdata;

  logic stallreq_if;
  logic stallreq_mem;

  modport master (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    input  bus_ready, bus_rdata,
    output stallreq_if, stallreq_mem
  );

  modport slave (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  bus_req, bus_we, bus_be, bus_addr, bus_wdata,
    output bus_ready, bus_rdata,
    input  stallreq_if, stallreq_mem
  );

endinterface

// File: rtl/mem_arbiter_pick2.sv
// Two-way request picker; data wins ties unless MEM_ARB_RR_EN,
// where the side that did not win last time takes the tie.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic   req_i,
  input  logic   req_d,
  input  owner_e last_owner,
  output logic   grant_valid,
  output owner_e grant_owner
);

  owner_e tie_owner;

`ifdef MEM_ARB_RR_EN
  assign tie_owner = (last_owner == OWN_I) ? OWN_D : OWN_I;
`else
  logic unused_last;
  assign unused_last = last_owner;
  assign tie_owner   = OWN_D;
`endif

  always_comb begin
    grant_valid = req_i | req_d;
    grant_owner = OWN_I;
    unique case (1'b1)
      (req_i & req_d):  grant_owner = tie_owner;
      (req_d & ~req_i): grant_owner = OWN_D;
      default:          grant_owner = OWN_I;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises IF and MEM requests onto one memory bus port.
// Define MEM_ARB_RR_EN for round-robin tie-breaking.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.master mif
);

  localparam int BE_W = DATA_W / 8;

  state_e state_q, state_d;
  owner_e last_owner, pick_owner;

  logic pick_valid, arb_pt, grant;
  logic gnt_i, gnt_d;
  logic busy_i, busy_d, ret_i, ret_d;

  logic              bus_we_q;
  logic [BE_W-1:0]   bus_be_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;

  logic              rvalid_i_q, rvalid_d_q;
  logic [DATA_W-1:0] rdata_i_q, rdata_d_q;

`ifdef MEM_ARB_RR_EN
  owner_e last_q;
  always_ff @(posedge clk) begin
    if (rst)        last_q <= OWN_I;
    else if (grant) last_q <= pick_owner;
  end
  assign last_owner = last_q;
`else
  assign last_owner = OWN_I;
`endif

  arb_pick2 u_pick (
    .req_i       (mif.if_req),
    .req_d       (mif.dm_req),
    .last_owner  (last_owner),
    .grant_valid (pick_valid),
    .grant_owner (pick_owner)
  );

  assign busy_i = (state_q == BUSY_I);
  assign busy_d = (state_q == BUSY_D);
  assign ret_i  = busy_i & mif.bus_ready;
  assign ret_d  = busy_d & mif.bus_ready;

  // The completing cycle doubles as the next arbitration point.
  assign arb_pt = ~rst & ((state_q == IDLE) | mif.bus_ready);
  assign grant  = arb_pt & pick_valid;
  assign gnt_i  = grant & (pick_owner == OWN_I);
  assign gnt_d  = grant & (pick_owner == OWN_D);

  always_comb begin
    state_d = state_q;
    if (arb_pt) begin
      if (!grant)                   state_d = IDLE;
      else if (pick_owner == OWN_D) state_d = BUSY_D;
      else                          state_d = BUSY_I;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bus_we_q    <= 1'b0;
      bus_be_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rvalid_i_q  <= 1'b0;
      rvalid_d_q  <= 1'b0;
      rdata_i_q   <= '0;
      rdata_d_q   <= '0;
    end else begin
      state_q    <= state_d;
      rvalid_i_q <= ret_i;
      rvalid_d_q <= ret_d;
      if (ret_i) rdata_i_q <= mif.bus_rdata;
      if (ret_d) rdata_d_q <= bus_we_q ? '0 : mif.bus_rdata;
      if (gnt_d) begin
        bus_we_q    <= mif.dm_we;
        bus_be_q    <= mif.dm_be;
        bus_addr_q  <= mif.dm_addr;
        bus_wdata_q <= mif.dm_wdata;
      end else if (gnt_i) begin
        bus_we_q    <= 1'b0;
        bus_be_q    <= '1;
        bus_addr_q  <= mif.if_addr;
        bus_wdata_q <= '0;
      end
    end
  end

  assign mif.if_gnt    = gnt_i;
  assign mif.dm_gnt    = gnt_d;
  assign mif.if_rvalid = rvalid_i_q;
  assign mif.dm_rvalid = rvalid_d_q;
  assign mif.if_rdata  = rdata_i_q;
  assign mif.dm_rdata  = rdata_d_q;

  assign mif.bus_req   = (state_q != IDLE);
  assign mif.bus_we    = bus_we_q;
  assign mif.bus_be    = bus_be_q;
  assign mif.bus_addr  = bus_addr_q;
  assign mif.bus_wdata = bus_wdata_q;

  // A requester stalls from its request (grant cycle included) until rvalid.
  assign mif.stallreq_if  = ~rst & (mif.if_req | busy_i) & ~rvalid_i_q;
  assign mif.stallreq_mem = ~rst & (mif.dm_req | busy_d) & ~rvalid_d_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corners, random vs model.
// Expectations follow MEM_ARB_RR_EN when it is defined.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .mif (mif)
  );

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // {if_gnt, dm_gnt, if_rvalid, dm_rvalid, bus_req, bus_we, stall_if, stall_mem}
  function automatic logic [7:0] ctl();
    return {mif.if_gnt, mif.dm_gnt, mif.if_rvalid, mif.dm_rvalid,
            mif.bus_req, mif.bus_we, mif.stallreq_if, mif.stallreq_mem};
  endfunction

  task automatic idle_in();
    mif.if_req    = 1'b0;
    mif.if_addr   = '0;
    mif.dm_req    = 1'b0;
    mif.dm_we     = 1'b0;
    mif.dm_be     = '0;
    mif.dm_addr   = '0;
    mif.dm_wdata  = '0;
    mif.bus_ready = 1'b0;
    mif.bus_rdata = '0;
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic [7:0]  e_ctl;
    logic [31:0] e_bus_addr;
    logic [31:0] e_if_rdata;
    logic [31:0] e_dm_rdata;
  } vec_t;

  vec_t vt[9];

  // Reference model state: the transaction on the bus and pending replies.
  logic        m_busy, m_own, m_we, m_last;
  logic [3:0]  m_be;
  logic [31:0] m_addr, m_wdata;
  logic        m_rv_i, m_rv_d;
  logic [31:0] m_rd_i, m_rd_d;
  logic        e_gi, e_gd, e_si, e_sm;

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_we = 0; m_last = 0;
    m_be = '0; m_addr = '0; m_wdata = '0;
    m_rv_i = 0; m_rv_d = 0; m_rd_i = '0; m_rd_d = '0;
  endtask

  task automatic model_expect();
    logic free, d_first;
    free    = !m_busy || mif.bus_ready;
    d_first = RR ? !m_last : 1'b1;
    e_gd = !rst && free && mif.dm_req && (!mif.if_req || d_first);
    e_gi = !rst && free && mif.if_req && !e_gd;
    e_si = !rst && (mif.if_req || (m_busy && !m_own)) && !m_rv_i;
    e_sm = !rst && (mif.dm_req || (m_busy && m_own)) && !m_rv_d;
  endtask

  task automatic model_step();
    logic done;
    if (rst) begin
      model_reset();
      return;
    end
    done   = m_busy && mif.bus_ready;
    m_rv_i = done && !m_own;
    m_rv_d = done && m_own;
    if (m_rv_i) m_rd_i = mif.bus_rdata;
    if (m_rv_d) m_rd_d = m_we ? 32'h0 : mif.bus_rdata;
    if (e_gd) begin
      m_busy = 1; m_own = 1; m_last = 1;
      m_we = mif.dm_we; m_be = mif.dm_be;
      m_addr = mif.dm_addr; m_wdata = mif.dm_wdata;
    end else if (e_gi) begin
      m_busy = 1; m_own = 0; m_last = 0;
      m_we = 0; m_be = 4'hF;
      m_addr = mif.if_addr; m_wdata = '0;
    end else if (done) begin
      m_busy = 0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic i_out, d_out, gi, gd, rvi, rvd;
    logic [7:0] e_ctl;
    bit q[$];

    // Reset with both requests raised: nothing may be granted.
    rst = 1'b1;
    idle_in();
    mif.if_req = 1'b1;
    mif.dm_req = 1'b1;
    to_next();
    @(negedge clk);
    chk("rst ctl", ctl(), 8'h00);
    chk("rst bus", {mif.bus_be, mif.bus_addr}, 36'h0);
    chk("rst wdata", mif.bus_wdata, 32'h0);
    chk("rst rdata", {mif.if_rdata, mif.dm_rdata}, 64'h0);
    to_next();
    rst = 1'b0;
    idle_in();

    vt[0] = '{1, 32'h100, 0, 0, 4'h0, 0, 0, 0, 0,
              8'b1000_0010, 32'h0, 32'h0, 32'h0};
    vt[1] = '{0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h00500093,
              8'b0000_1010, 32'h100, 32'h0, 32'h0};
    vt[2] = '{0, 0, 0, 0, 4'h0, 0, 0, 0, 0,
              8'b0010_0000, 32'h100, 32'h00500093, 32'h0};
    vt[3] = '{1, 32'h104, 1, 0, 4'hF, 32'h2000, 0, 0, 0,
              8'b0100_0011, 32'h100, 32'h00500093, 32'h0};
    vt[4] = '{1, 32'h104, 0, 0, 4'h0, 0, 0, 1, 32'h11112222,
              8'b1000_1011, 32'h2000, 32'h00500093, 32'h0};
    vt[5] = '{0, 0, 0, 0, 4'h0, 0, 0, 1, 32'h33334444,
              8'b0001_1010, 32'h104, 32'h00500093, 32'h11112222};
    vt[6] = '{0, 0, 0, 0, 4'h0, 0, 0, 0, 0,
              8'b0010_0000, 32'h104, 32'h33334444, 32'h11112222};
    vt[7] = '{0, 0, 0, 0, 4'h0, 0, 0, 1, 32'hFFFFFFFF,
              8'b0000_0000, 32'h104, 32'h33334444, 32'h11112222};
    vt[8] = '{0, 0, 0, 0, 4'h0, 0, 0, 0, 0,
              8'b0000_0000, 32'h104, 32'h33334444, 32'h11112222};

    for (int i = 0; i < 9; i++) begin
      mif.if_req    = vt[i].if_req;
      mif.if_addr   = vt[i].if_addr;
      mif.dm_req    = vt[i].dm_req;
      mif.dm_we     = vt[i].dm_we;
      mif.dm_be     = vt[i].dm_be;
      mif.dm_addr   = vt[i].dm_addr;
      mif.dm_wdata  = vt[i].dm_wdata;
      mif.bus_ready = vt[i].bus_ready;
      mif.bus_rdata = vt[i].bus_rdata;
      @(negedge clk);
      chk($sformatf("vec%0d ctl", i), ctl(), vt[i].e_ctl);
      chk($sformatf("vec%0d addr", i), mif.bus_addr, vt[i].e_bus_addr);
      chk($sformatf("vec%0d if_rdata", i), mif.if_rdata, vt[i].e_if_rdata);
      chk($sformatf("vec%0d dm_rdata", i), mif.dm_rdata, vt[i].e_dm_rdata);
      to_next();
    end
    idle_in();

    // Store held off by three wait states.
    mif.dm_req   = 1'b1;
    mif.dm_we    = 1'b1;
    mif.dm_be    = 4'b0011;
    mif.dm_addr  = 32'h2004;
    mif.dm_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("st gnt", {mif.dm_gnt, mif.stallreq_mem}, 2'b11);
    to_next();
    idle_in();
    for (int k = 0; k < 4; k++) begin
      mif.bus_ready = (k == 3);
      mif.bus_rdata = 32'hCAFEF00D;
      @(negedge clk);
      chk($sformatf("st%0d fields", k),
          {mif.bus_req, mif.bus_we, mif.bus_be, mif.bus_addr}, {2'b11, 4'h3, 32'h2004});
      chk($sformatf("st%0d wdata", k), mif.bus_wdata, 32'hDEADBEEF);
      chk($sformatf("st%0d stall", k), {mif.stallreq_mem, mif.dm_rvalid}, 2'b10);
      to_next();
    end
    idle_in();
    @(negedge clk);
    chk("st ack", {mif.dm_rvalid, mif.stallreq_mem}, 2'b10);
    chk("st rdata", mif.dm_rdata, 32'h0);
    to_next();

    // Tie from idle right after a data-side win.
    mif.if_req  = 1'b1;
    mif.if_addr = 32'h200;
    mif.dm_req  = 1'b1;
    mif.dm_be   = 4'hF;
    mif.dm_addr = 32'h2100;
    @(negedge clk);
    chk("tie gnt", {mif.if_gnt, mif.dm_gnt}, RR ? 2'b10 : 2'b01);
    to_next();
    if (RR) mif.if_req = 1'b0;
    else mif.dm_req = 1'b0;
    mif.bus_ready = 1'b1;
    mif.bus_rdata = 32'h0A0A0A0A;
    @(negedge clk);
    chk("tie 2nd gnt", {mif.if_gnt, mif.dm_gnt}, RR ? 2'b01 : 2'b10);
    chk("tie addr", mif.bus_addr, RR ? 32'h200 : 32'h2100);
    to_next();
    idle_in();
    mif.bus_ready = 1'b1;
    mif.bus_rdata = 32'h0B0B0B0B;
    @(negedge clk);
    chk("tie rv1", {mif.if_rvalid, mif.dm_rvalid}, RR ? 2'b10 : 2'b01);
    chk("tie rd1", RR ? mif.if_rdata : mif.dm_rdata, 32'h0A0A0A0A);
    to_next();
    idle_in();
    @(negedge clk);
    chk("tie rv2", {mif.if_rvalid, mif.dm_rvalid}, RR ? 2'b01 : 2'b10);
    to_next();

    // Reset while a load is on the bus.
    mif.dm_req  = 1'b1;
    mif.dm_be   = 4'hF;
    mif.dm_addr = 32'h3000;
    @(negedge clk);
    chk("rm gnt", mif.dm_gnt, 1'b1);
    to_next();
    idle_in();
    @(negedge clk);
    chk("rm busy", {mif.bus_req, mif.bus_addr}, {1'b1, 32'h3000});
    to_next();
    rst = 1'b1;
    @(negedge clk);
    chk("rm rst outs", {mif.dm_gnt, mif.stallreq_mem}, 2'b00);
    to_next();
    rst = 1'b0;
    mif.bus_ready = 1'b1;
    mif.bus_rdata = 32'h12345678;
    @(negedge clk);
    chk("rm after", {mif.bus_req, mif.bus_addr}, 33'h0);
    to_next();
    for (int k = 0; k < 4; k++) begin
      mif.bus_ready = k[0];
      @(negedge clk);
      chk($sformatf("rm quiet%0d", k),
          {mif.dm_rvalid, mif.bus_req, mif.dm_rdata}, 34'h0);
      to_next();
    end
    mif.bus_ready = 1'b0;
    mif.dm_req    = 1'b1;
    mif.dm_be     = 4'hF;
    mif.dm_addr   = 32'h3004;
    @(negedge clk);
    chk("rm idle gnt", mif.dm_gnt, 1'b1);
    to_next();
    idle_in();
    mif.bus_ready = 1'b1;
    mif.bus_rdata = 32'h55AA55AA;
    to_next();
    idle_in();
    @(negedge clk);
    chk("rm new rdata", {mif.dm_rvalid, mif.dm_rdata}, {1'b1, 32'h55AA55AA});
    to_next();

    // Both sides re-request as soon as allowed; zero wait states.
    rst = 1'b1;
    to_next();
    rst = 1'b0;
    i_out = 0;
    d_out = 0;
    for (int c = 0; c < 40 && q.size() < 4; c++) begin
      mif.bus_ready = 1'b1;
      mif.bus_rdata = $urandom();
      if (!i_out && !mif.if_req) begin
        mif.if_req  = 1'b1;
        mif.if_addr = 32'h400 + 32'(c * 4);
      end
      if (!d_out && !mif.dm_req) begin
        mif.dm_req  = 1'b1;
        mif.dm_we   = 1'b0;
        mif.dm_be   = 4'hF;
        mif.dm_addr = 32'h5000 + 32'(c * 4);
      end
      @(negedge clk);
      gi  = mif.if_gnt;
      gd  = mif.dm_gnt;
      rvi = mif.if_rvalid;
      rvd = mif.dm_rvalid;
      if (gd) q.push_back(1'b1);
      if (gi) q.push_back(1'b0);
      to_next();
      if (gi) begin mif.if_req = 1'b0; i_out = 1; end
      if (gd) begin mif.dm_req = 1'b0; d_out = 1; end
      if (rvi) i_out = 0;
      if (rvd) d_out = 0;
    end
    chk("alt count", 64'(q.size() >= 4), 64'h1);
    for (int k = 0; k < 4; k++)
      chk($sformatf("alt grant%0d", k),
          (k < q.size()) ? q[k] : 1'bx, (k % 2 == 0) ? 1'b1 : 1'b0);

    // Random traffic against the model, with occasional resets.
    idle_in();
    rst = 1'b1;
    to_next();
    model_reset();
    rst = 1'b0;
    i_out = 0;
    d_out = 0;
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!mif.if_req && !i_out && $urandom_range(0, 2) == 0) begin
        mif.if_req  = 1'b1;
        mif.if_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!mif.dm_req && !d_out && $urandom_range(0, 2) == 0) begin
        mif.dm_req   = 1'b1;
        mif.dm_we    = 1'($urandom());
        mif.dm_be    = 4'($urandom());
        mif.dm_addr  = $urandom();
        mif.dm_wdata = $urandom();
      end
      mif.bus_ready = ($urandom_range(0, 2) != 0);
      mif.bus_rdata = $urandom();
      @(negedge clk);
      model_expect();
      e_ctl = {e_gi, e_gd, m_rv_i, m_rv_d, m_busy, m_we, e_si, e_sm};
      chk($sformatf("rnd%0d ctl", c), {ctl(), mif.bus_be}, {e_ctl, m_be});
      chk($sformatf("rnd%0d addr", c), mif.bus_addr, m_addr);
      chk($sformatf("rnd%0d wdata", c), mif.bus_wdata, m_wdata);
      chk($sformatf("rnd%0d rdata", c),
          {mif.if_rdata, mif.dm_rdata}, {m_rd_i, m_rd_d});
      gi  = e_gi;
      gd  = e_gd;
      rvi = m_rv_i;
      rvd = m_rv_d;
      @(posedge clk);
      model_step();
      #1;
      if (rst) begin
        mif.if_req = 1'b0;
        mif.dm_req = 1'b0;
        i_out = 0;
        d_out = 0;
      end else begin
        if (gi) begin mif.if_req = 1'b0; i_out = 1; end
        if (gd) begin mif.dm_req = 1'b0; d_out = 1; end
        if (rvi) i_out = 0;
        if (rvd) d_out = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
